// File: rtl/transfer_center_rx_if.sv
// Handshake/bus bundle for the transfer center serial receiver.
// master = stimulus side, slave = receiver side.
interface transfer_center_rx_if #(
  parameter int WORD_W     = 8,
  parameter int FIFO_DEPTH = 16
);
  localparam int CountW = $clog2(FIFO_DEPTH) + 1;

  logic              serial_in;
  logic              frame_sync;
  logic              ready_in;
  logic              ready_out;
  logic [1:0]        scanner_cmd;
  logic [WORD_W-1:0] data_out;
  logic              data_ascii;
  logic              data_valid;
  logic              data_ready;
  logic [CountW-1:0] fifo_count;
  logic              overflow;
  logic              err_cmd;
  logic              err_frame;

  modport master (
    output serial_in, frame_sync, ready_in, data_ready,
    input  ready_out, scanner_cmd, data_out, data_ascii, data_valid,
           fifo_count, overflow, err_cmd, err_frame
  );

  modport slave (
    input  serial_in, frame_sync, ready_in, data_ready,
    output ready_out, scanner_cmd, data_out, data_ascii, data_valid,
           fifo_count, overflow, err_cmd, err_frame
  );
endinterface

// File: rtl/transfer_center_rx.sv
// Serial command/payload receiver: deserialises words, decodes buffer-status
// commands and queues length-delimited binary/ASCII payloads in a FIFO.
//
// state | meaning
// CMD   | next word is a command code
// LEN   | next word is the payload length
// DATA  | next words are payload, `remaining` still to come
module transfer_center_rx #(
  parameter int WORD_W     = 8,
  parameter int FIFO_DEPTH = 16
) (
  input logic                 clk,
  input logic                 rst,
  transfer_center_rx_if.slave bus
);
  localparam int CntW  = $clog2(WORD_W);
  localparam int AddrW = $clog2(FIFO_DEPTH);
  localparam logic [CntW-1:0]  LastBit   = CntW'(WORD_W - 1);
  localparam logic [CntW-1:0]  CntOne    = CntW'(1);
  localparam logic [AddrW:0]   FullCount = (AddrW+1)'(FIFO_DEPTH);
  localparam logic [AddrW:0]   CountOne  = (AddrW+1)'(1);
  localparam logic [AddrW-1:0] PtrOne    = AddrW'(1);

  typedef enum logic [1:0] {CMD, LEN, DATA} stateType;

  stateType          state, nextState;
  logic [WORD_W-1:0] sh, word, remaining;
  logic [CntW-1:0]   cnt, effCnt;
  logic              strobe, frameErr;
  logic              tag, tagNext, setTag;
  logic              loadReady, clearReady, readyOut;
  logic [1:0]        scanNext, scanCmd;
  logic              errCmdNext, errCmd, errFrame;
  logic              flushReq, loadLen, pushReq;

  logic [WORD_W:0]    mem [FIFO_DEPTH];
  logic [AddrW-1:0]   wrPtr, rdPtr;
  logic [AddrW:0]     count;
  logic               popReq, fullBlock, doPush, ovf;

  // frame_sync restarts the word, so it can never coincide with a strobe
  always_comb begin
    effCnt   = bus.frame_sync ? '0 : cnt;
    strobe   = (effCnt == LastBit);
    frameErr = bus.frame_sync && (cnt != '0);
    word     = {sh[WORD_W-2:0], bus.serial_in};
  end

  always_ff @(posedge clk) begin
    if (rst) state <= CMD;
    else     state <= nextState;
  end

  always_comb begin
    nextState  = state;
    loadReady  = 1'b0;
    clearReady = 1'b0;
    scanNext   = 2'b00;
    errCmdNext = 1'b0;
    flushReq   = 1'b0;
    loadLen    = 1'b0;
    pushReq    = 1'b0;
    setTag     = 1'b0;
    tagNext    = tag;
    if (frameErr) begin
      nextState = CMD;
    end else if (strobe) begin
      case (state)
        CMD: begin
          case (word)
            WORD_W'(0): begin end
            WORD_W'(1): begin
              clearReady = 1'b1;
              scanNext   = 2'b10;
            end
            WORD_W'(2), WORD_W'(4), WORD_W'(6): loadReady = 1'b1;
            WORD_W'(3): begin
              loadReady = 1'b1;
              scanNext  = 2'b01;
            end
            WORD_W'(5): flushReq = 1'b1;
            WORD_W'(7), WORD_W'(8): begin
              loadReady = 1'b1;
              setTag    = 1'b1;
              tagNext   = (word == WORD_W'(8));
              nextState = LEN;
            end
            default: errCmdNext = 1'b1;
          endcase
        end
        LEN: begin
          loadLen   = 1'b1;
          nextState = (word == '0) ? CMD : DATA;
        end
        DATA: begin
          pushReq = 1'b1;
          if (remaining == WORD_W'(1)) nextState = CMD;
        end
        default: nextState = CMD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh        <= '0;
      cnt       <= '0;
      remaining <= '0;
      tag       <= 1'b0;
      readyOut  <= 1'b0;
      scanCmd   <= 2'b00;
      errCmd    <= 1'b0;
      errFrame  <= 1'b0;
    end else begin
      sh       <= word;
      cnt      <= strobe ? '0 : effCnt + CntOne;
      scanCmd  <= scanNext;
      errCmd   <= errCmdNext;
      errFrame <= frameErr;
      if (clearReady)     readyOut <= 1'b0;
      else if (loadReady) readyOut <= bus.ready_in;
      if (setTag) tag <= tagNext;
      if (loadLen)      remaining <= word;
      else if (pushReq) remaining <= remaining - WORD_W'(1);
    end
  end

  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign popReq    = (count != '0) && bus.data_ready;
  assign fullBlock = (count == FullCount) && !popReq;
  assign doPush    = pushReq && !fullBlock;

  always_ff @(posedge clk) begin
    if (rst || flushReq) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PtrOne;
      if (popReq) rdPtr <= rdPtr + PtrOne;
      if (pushReq && fullBlock) ovf <= 1'b1;
      case ({doPush, popReq})
        2'b10:   count <= count + CountOne;
        2'b01:   count <= count - CountOne;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= {tag, word};
  end

  assign bus.data_valid  = (count != '0);
  assign bus.data_out    = bus.data_valid ? mem[rdPtr][WORD_W-1:0] : '0;
  assign bus.data_ascii  = bus.data_valid ? mem[rdPtr][WORD_W] : 1'b0;
  assign bus.fifo_count  = count;
  assign bus.overflow    = ovf;
  assign bus.ready_out   = readyOut;
  assign bus.scanner_cmd = scanCmd;
  assign bus.err_cmd     = errCmd;
  assign bus.err_frame   = errFrame;
endmodule

// File: tb/tb_transfer_center_rx.sv
// Randomised bench for transfer_center_rx against a word-level queue model;
// a second 12-bit instance covers the wide-word configuration.
module tb_transfer_center_rx;
  localparam int W     = 8;
  localparam int W12   = 12;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst12 = 1'b1;
  always #5 clk = ~clk;

  transfer_center_rx_if #(.WORD_W(W),   .FIFO_DEPTH(DEPTH)) bus8 ();
  transfer_center_rx_if #(.WORD_W(W12), .FIFO_DEPTH(DEPTH)) bus12 ();

  transfer_center_rx #(.WORD_W(W), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus8)
  );
  transfer_center_rx #(.WORD_W(W12), .FIFO_DEPTH(DEPTH)) dut12 (
    .clk(clk), .rst(rst12), .bus(bus12)
  );

  typedef struct packed {
    logic         tag;
    logic [W-1:0] w;
  } entryT;

  int nChecks = 0;
  int nFails  = 0;

  // word-level reference model
  entryT q[$];
  int    mState;     // 0 command, 1 length, 2 payload
  int    mRem;
  bit    mTag, mReady, mOvf;
  bit [1:0] eScan;
  bit    eErrCmd, eErrFrame;
  int    drMode;     // 0 stalled, 1 always ready, 2 random

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic checkOutputs();
    checkVal("ready_out",   32'(bus8.ready_out),   32'(mReady));
    checkVal("scanner_cmd", 32'(bus8.scanner_cmd), 32'(eScan));
    checkVal("err_cmd",     32'(bus8.err_cmd),     32'(eErrCmd));
    checkVal("err_frame",   32'(bus8.err_frame),   32'(eErrFrame));
    checkVal("overflow",    32'(bus8.overflow),    32'(mOvf));
    checkVal("fifo_count",  32'(bus8.fifo_count),  32'(q.size()));
    checkVal("data_valid",  32'(bus8.data_valid),  32'(q.size() != 0));
    if (q.size() != 0) begin
      checkVal("data_out",   32'(bus8.data_out),   32'(q[0].w));
      checkVal("data_ascii", 32'(bus8.data_ascii), 32'(q[0].tag));
    end
  endtask

  task automatic tick(input logic sin, input logic fs, input bit last,
                      input logic [W-1:0] w, input bit frameErr);
    bit    doPop, flush, push;
    entryT e;
    bus8.serial_in  = sin;
    bus8.frame_sync = fs;
    bus8.data_ready = (drMode == 0) ? 1'b0 : (drMode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
    doPop     = (q.size() != 0) && bus8.data_ready;
    flush     = 0;
    push      = 0;
    eScan     = 2'b00;
    eErrCmd   = 0;
    eErrFrame = frameErr;
    if (frameErr) begin
      mState = 0;
    end else if (last) begin
      case (mState)
        0: case (int'(w))
          0: ;
          1: begin mReady = 0; eScan = 2'b10; end
          2, 4, 6: mReady = bus8.ready_in;
          3: begin mReady = bus8.ready_in; eScan = 2'b01; end
          5: flush = 1;
          7: begin mReady = bus8.ready_in; mTag = 0; mState = 1; end
          8: begin mReady = bus8.ready_in; mTag = 1; mState = 1; end
          default: eErrCmd = 1;
        endcase
        1: begin mRem = int'(w); mState = (w == 0) ? 0 : 2; end
        default: begin
          push = 1;
          mRem--;
          if (mRem == 0) mState = 0;
        end
      endcase
    end
    if (flush) begin
      q.delete();
      mOvf = 0;
    end else begin
      if (doPop) void'(q.pop_front());
      if (push) begin
        if (q.size() < DEPTH) begin
          e.tag = mTag;
          e.w   = w;
          q.push_back(e);
        end else begin
          mOvf = 1;
        end
      end
    end
    @(posedge clk);
    #1;
    checkOutputs();
  endtask

  // fe marks a frame_sync that cuts a partial word short
  task automatic sendWord(input logic [W-1:0] w, input bit fs, input bit fe);
    for (int i = W - 1; i >= 0; i--)
      tick(w[i], (i == W - 1) && fs, i == 0, w, (i == W - 1) && fe);
  endtask

  task automatic sendPartial(input logic [W-1:0] w, input int nBits);
    for (int i = 0; i < nBits; i++)
      tick(w[W-1-i], 1'b0, 1'b0, w, 1'b0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    bus8.serial_in  = 1'b0;
    bus8.frame_sync = 1'b0;
    bus8.data_ready = 1'b0;
    @(posedge clk);
    #1;
    q.delete();
    mState = 0; mRem = 0; mTag = 0; mReady = 0; mOvf = 0;
    eScan = 2'b00; eErrCmd = 0; eErrFrame = 0;
    checkVal("rst_ready_out",  32'(bus8.ready_out),   32'd0);
    checkVal("rst_scanner",    32'(bus8.scanner_cmd), 32'd0);
    checkVal("rst_fifo_count", 32'(bus8.fifo_count),  32'd0);
    checkVal("rst_overflow",   32'(bus8.overflow),    32'd0);
    checkVal("rst_data_valid", 32'(bus8.data_valid),  32'd0);
    checkVal("rst_err_cmd",    32'(bus8.err_cmd),     32'd0);
    checkVal("rst_err_frame",  32'(bus8.err_frame),   32'd0);
    checkVal("rst_data_out",   32'(bus8.data_out),    32'd0);
    rst = 1'b0;
  endtask

  task automatic tick12(input logic sin);
    bus12.serial_in = sin;
    @(posedge clk);
    #1;
  endtask

  task automatic send12(input logic [W12-1:0] w);
    for (int i = W12 - 1; i >= 0; i--) tick12(w[i]);
  endtask

  initial begin
    logic [W-1:0]   rw;
    logic [W12-1:0] w1, w2;
    int sel, len;

    bus8.ready_in    = 1'b1;
    bus12.serial_in  = 1'b0;
    bus12.frame_sync = 1'b0;
    bus12.ready_in   = 1'b0;
    bus12.data_ready = 1'b0;
    drMode = 0;
    doReset();
    doReset();

    // status commands
    sendWord(8'd3, 1'b1, 1'b0);
    checkVal("t1_scan_start", 32'(bus8.scanner_cmd), 32'd1);
    checkVal("t1_ready_hi",   32'(bus8.ready_out),   32'd1);
    sendWord(8'd1, 1'b0, 1'b0);
    checkVal("t1_scan_flush", 32'(bus8.scanner_cmd), 32'd2);
    checkVal("t1_ready_lo",   32'(bus8.ready_out),   32'd0);

    // binary payload with stalled consumer, then drain
    sendWord(8'd7, 1'b0, 1'b0);
    sendWord(8'd3, 1'b0, 1'b0);
    sendWord(8'hA5, 1'b0, 1'b0);
    checkVal("t2_first_valid", 32'(bus8.data_valid), 32'd1);
    sendWord(8'h5A, 1'b0, 1'b0);
    sendWord(8'hFF, 1'b0, 1'b0);
    checkVal("t2_count", 32'(bus8.fifo_count), 32'd3);
    checkVal("t2_head",  32'(bus8.data_out),   32'hA5);
    checkVal("t2_ascii", 32'(bus8.data_ascii), 32'd0);
    drMode = 1;
    sendWord(8'd2, 1'b0, 1'b0);
    checkVal("t2_drained", 32'(bus8.fifo_count), 32'd0);
    checkVal("t2_cmd2",    32'(bus8.ready_out),  32'd1);

    // empty ASCII payload, then unknown command
    sendWord(8'd8, 1'b0, 1'b0);
    sendWord(8'd0, 1'b0, 1'b0);
    bus8.ready_in = 1'b0;
    sendWord(8'd9, 1'b0, 1'b0);
    checkVal("t3_err_cmd", 32'(bus8.err_cmd),    32'd1);
    checkVal("t3_no_push", 32'(bus8.fifo_count), 32'd0);
    checkVal("t3_ready",   32'(bus8.ready_out),  32'd1);

    // overflow then flush
    drMode = 0;
    sendWord(8'd7, 1'b0, 1'b0);
    sendWord(8'd18, 1'b0, 1'b0);
    for (int i = 0; i < 18; i++) sendWord(8'($urandom), 1'b0, 1'b0);
    checkVal("t4_full",     32'(bus8.fifo_count), 32'd16);
    checkVal("t4_overflow", 32'(bus8.overflow),   32'd1);
    sendWord(8'd5, 1'b0, 1'b0);
    checkVal("t4_flush_count", 32'(bus8.fifo_count), 32'd0);
    checkVal("t4_flush_ovf",   32'(bus8.overflow),   32'd0);

    // frame_sync mid payload word
    bus8.ready_in = 1'b1;
    sendWord(8'd7, 1'b0, 1'b0);
    sendWord(8'd2, 1'b0, 1'b0);
    sendPartial(8'hC3, 4);
    tick(1'b0, 1'b1, 1'b0, 8'd3, 1'b1);
    checkVal("t5_err_frame", 32'(bus8.err_frame), 32'd1);
    for (int i = W - 2; i >= 0; i--) tick(1'(i <= 1), 1'b0, i == 0, 8'd3, 1'b0);
    checkVal("t5_cmd_after", 32'(bus8.scanner_cmd), 32'd1);
    checkVal("t5_no_push",   32'(bus8.fifo_count),  32'd0);

    // reset mid payload
    sendWord(8'd7, 1'b0, 1'b0);
    sendWord(8'd5, 1'b0, 1'b0);
    sendWord(8'h11, 1'b0, 1'b0);
    sendWord(8'h22, 1'b0, 1'b0);
    checkVal("t6_queued", 32'(bus8.fifo_count), 32'd2);
    sendPartial(8'h33, 3);
    doReset();
    sendWord(8'd3, 1'b0, 1'b0);
    checkVal("t6_cmd_after_rst", 32'(bus8.scanner_cmd), 32'd1);

    // randomised traffic
    for (int n = 0; n < 120; n++) begin
      drMode = int'($urandom_range(0, 2));
      bus8.ready_in = 1'($urandom_range(0, 1));
      sel = int'($urandom_range(0, 9));
      if (sel < 4) begin
        len = int'($urandom_range(0, 20));
        sendWord(8'($urandom_range(7, 8)), 1'($urandom_range(0, 1)), 1'b0);
        sendWord(8'(len), 1'b0, 1'b0);
        for (int j = 0; j < len; j++) sendWord(8'($urandom), 1'b0, 1'b0);
      end else if (sel == 4) begin
        rw = 8'($urandom);
        sendPartial(rw, int'($urandom_range(1, W - 1)));
        sendWord(8'($urandom_range(0, 15)), 1'b1, 1'b1);
      end else begin
        sendWord(8'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0);
      end
    end

    // 12-bit configuration
    tick12(1'b0);
    rst12 = 1'b0;
    bus12.ready_in = 1'b1;
    w1 = 12'($urandom);
    w2 = 12'($urandom);
    send12(12'd7);
    checkVal("w12_ready", 32'(bus12.ready_out), 32'd1);
    send12(12'd2);
    send12(w1);
    send12(w2);
    checkVal("w12_count", 32'(bus12.fifo_count), 32'd2);
    checkVal("w12_head1", 32'(bus12.data_out),   32'(w1));
    checkVal("w12_ascii", 32'(bus12.data_ascii), 32'd0);
    bus12.data_ready = 1'b1;
    tick12(1'b0);
    checkVal("w12_head2", 32'(bus12.data_out), 32'(w2));
    tick12(1'b0);
    checkVal("w12_empty", 32'(bus12.data_valid), 32'd0);
    bus12.data_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule

// File: doc/transfer_center_rx.md
# transfer_center_rx

Parametrised serial command/payload receiver for the transfer center. Deserialises a bit stream into WORD_W-bit words, decodes buffer-status commands into `ready_out` and scanner control, and routes length-delimited binary/ASCII payloads into an internal FIFO with a valid/ready output. It replaces the fixed 8-bit receiver: word width and FIFO depth are configurable, word alignment is explicit, and payload end is set by a length word.

## Interface
- `WORD_W`, default 8: bits per serial word; also the width of the command, length and payload words.
- `FIFO_DEPTH`, default 16: payload FIFO entries; must be a power of two ≥2.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `serial_in`  in  1  serial data, MSB first, one bit per cycle.
- `frame_sync`  in  1  high when `serial_in` carries the MSB of a new word.
- `ready_in`  in  1  downstream transfer-ready status.
- `ready_out`  out  1  registered transfer-ready status.
- `scanner_cmd`  out  2  one-cycle pulse: 2'b10 flush, 2'b01 start scan, else 2'b00.
- `data_out`  out  WORD_W  FIFO head word.
- `data_ascii`  out  1  tag of head word: 1 = ASCII, 0 = binary.
- `data_valid`  out  1  FIFO not empty.
- `data_ready`  in  1  consumer accepts the head word.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- `overflow`  out  1  sticky: a payload word was dropped.
- `err_cmd`  out  1  one-cycle pulse: unknown command code.
- `err_frame`  out  1  one-cycle pulse: `frame_sync` arrived mid-word.

## Operation
- **Deserialiser:** shift register `sh` and bit counter `cnt` in 0..WORD_W-1.
  - Each cycle: `sh <= {sh[WORD_W-2:0], serial_in}`.
  - A word completes (strobe) when the effective count is WORD_W-1. The word value is `{sh[WORD_W-2:0], serial_in}`, decoded in that same cycle.
  - `frame_sync` forces the effective count to 0 for that cycle, so `cnt` becomes 1 after the edge.
  - If `frame_sync` is high while `cnt != 0`: discard the partial word, pulse `err_frame`, and return the FSM to CMD.
- **FSM states:** CMD, LEN, DATA. CMD is the reset state.
- **CMD, on strobe, by word value:**
  - 0: idle, no action.
  - 1: `ready_out <= 0`, `scanner_cmd` pulses 2'b10.
  - 2, 4, 6: `ready_out <= ready_in`.
  - 3: `ready_out <= ready_in`, `scanner_cmd` pulses 2'b01.
  - 5: flush FIFO (count to 0) and clear `overflow`.
  - 7: `ready_out <= ready_in`, tag <= binary, go to LEN.
  - 8: `ready_out <= ready_in`, tag <= ASCII, go to LEN.
  - Any other value: `err_cmd` pulses, stay in CMD.
- **LEN, on strobe:** `remaining <= word`. If word == 0, go to CMD; else go to DATA.
- **DATA, on strobe:** push `{tag, word}` into the FIFO and decrement `remaining`. When `remaining` was 1, go to CMD.
- **FIFO:** circular buffer. `data_out`/`data_ascii` show the head entry; `data_valid = (count != 0)`; pop when `data_valid && data_ready`.
- **Full FIFO:** a push with no pop in the same cycle drops the word and sets `overflow`. Push and pop in the same cycle when full: both happen, count unchanged, no overflow.
- **Empty FIFO:** `data_ready` has no effect.
- **Flush priority:** a flush overrides a same-cycle pop.
- **Reset:**
  - All outputs 0, including `ready_out`, `scanner_cmd`, `fifo_count`, `overflow`, the error pulses and `data_valid`.
  - FSM to CMD, `cnt`, `sh`, `remaining` and the FIFO pointers cleared.
  - Reset mid-payload discards the partial payload.

## Timing
- Strobe at edge k (the edge that samples the LSB): `ready_out`, `scanner_cmd`, the error flags, state and the FIFO push all become visible after edge k.
- Latency from LSB on `serial_in` to `data_valid`: 1 cycle when the FIFO is empty.
- `scanner_cmd`, `err_cmd` and `err_frame` are high for exactly one cycle.
- `ready_out` holds its value between commands. It samples `ready_in` only at command strobes.
- Pop: the head advances at the edge where `data_valid && data_ready`. The new head is visible the next cycle.
- Back-to-back words need no gap. `frame_sync` is optional after initial alignment, since `cnt` wraps from WORD_W-1 to 0.

## Test plan
- Reset, then send word 3 with `ready_in=1` → `ready_out=1` and `scanner_cmd=2'b01` for one cycle, after the LSB edge. Then send word 1 → `ready_out=0`, `scanner_cmd=2'b10` pulse.
- Send 7, 3, then 0xA5, 0x5A, 0xFF with `data_ready=0` → `fifo_count=3`, head 0xA5 with `data_ascii=0`. Raise `data_ready` → words pop in order. A following command 2 is decoded in CMD.
- Send 8, 0 → state returns to CMD after the length word, with no push. Then send 9 → `err_cmd` pulse, with no change to `ready_out`.
- With `FIFO_DEPTH=16`, send 7 and length 18 with the consumer stalled → 16 words stored, `overflow=1`. Then send 5 → `fifo_count=0` and `overflow=0`.
- Assert `frame_sync` at bit 4 of a payload word → `err_frame` pulse, FSM in CMD, and the next aligned word is decoded as a command.
- Assert `rst` mid-payload with 2 words queued → all outputs 0 next cycle and `fifo_count=0`. Run `WORD_W=12` regression: command 7, length 2, two 12-bit words → received intact.
